// File: rtl/iomem_wb_pkg.sv
// Shared types and helpers for the iomem-to-Wishbone bridge.
package iomem_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT  = 32'hDEAD_BEEF;
  localparam logic [7:0]  WB_REGION_DEFAULT = 8'h03;
  localparam int unsigned MAX_SLAVES        = 8;
  localparam int unsigned EXT_W             = 32 * MAX_SLAVES;

  // Extract 32-bit field k from a packed per-slave vector (widened to EXT_W).
  function automatic logic [31:0] slave_field(input logic [EXT_W-1:0] vec,
                                              input int unsigned k);
    return vec[32*k +: 32];
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Priority address decoder: one-hot hit vector, lowest index wins on overlap.
module wb_addr_decoder
  import iomem_wb_pkg::*;
#(
  parameter int unsigned                   NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]      SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]      SLAVE_MASK = {NUM_SLAVES{32'hFFFF_0000}}
) (
  input  logic [31:0]           addr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  any_hit_o
);

  localparam logic [EXT_W-1:0] BASE_EXT = EXT_W'(SLAVE_BASE);
  localparam logic [EXT_W-1:0] MASK_EXT = EXT_W'(SLAVE_MASK);

  // First matching window claims the address; later matches are suppressed.
  always_comb begin
    hit_o     = '0;
    any_hit_o = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!any_hit_o &&
          ((addr_i & slave_field(MASK_EXT, k)) == slave_field(BASE_EXT, k))) begin
        hit_o[k]  = 1'b1;
        any_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iomem_wb_bridge.sv
// PicoSoC iomem to multi-slave Wishbone B4 classic bridge with bus-error handling.
module iomem_wb_bridge
  import iomem_wb_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_0000}},
  parameter logic [7:0]               WB_REGION  = WB_REGION_DEFAULT,
  parameter int unsigned              TIMEOUT    = 255,
  parameter logic [31:0]              ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [NUM_SLAVES-1:0]    wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    wb_stb_o,
  input  logic [32*NUM_SLAVES-1:0] wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    wb_ack_i,
  output logic                     err_o,
  output logic [31:0]              err_addr_o,
  input  logic                     err_clr_i
);

  // Width guard keeps the timer at least one bit when the timeout is disabled.
  localparam int unsigned  TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                  state_q;
  logic [TW-1:0]           timer_q;
  logic                    ready_q;
  logic [31:0]             rdata_q;
  logic [31:0]             adr_q;
  logic [31:0]             dat_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [NUM_SLAVES-1:0]   cyc_q;
  logic [NUM_SLAVES-1:0]   stb_q;
  logic                    err_q;
  logic [31:0]             err_addr_q;

  logic [NUM_SLAVES-1:0]   hit;
  logic                    any_hit;
  logic                    in_region;
  logic                    ack_sel;
  logic                    timeout_hit;
  logic [31:0]             ack_data;
  logic [EXT_W-1:0]        dat_ext;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr_i    (iomem_addr),
    .hit_o     (hit),
    .any_hit_o (any_hit)
  );

  assign in_region   = (iomem_addr[31:24] >= WB_REGION);
  assign ack_sel     = |(wb_ack_i & cyc_q);
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);
  assign dat_ext     = EXT_W'(wb_dat_i);

  // Read-data mux driven by the active one-hot cycle.
  always_comb begin
    ack_data = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (cyc_q[k]) ack_data = slave_field(dat_ext, k);
    end
  end

  // Bridge FSM with registered bus outputs and sticky error capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      cyc_q      <= '0;
      stb_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // A clear is overridden below if a new error lands in the same cycle.
      if (err_clr_i) err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iomem_valid && in_region) begin
            if (any_hit) begin
              adr_q   <= iomem_addr;
              dat_q   <= iomem_wdata;
              we_q    <= |iomem_wstrb;
              sel_q   <= (|iomem_wstrb) ? iomem_wstrb : 4'hF;
              cyc_q   <= hit;
              stb_q   <= hit;
              timer_q <= '0;
              state_q <= ST_ACTIVE;
            end else begin
              rdata_q <= ERR_DATA;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              if (!err_q || err_clr_i) err_addr_q <= iomem_addr;
              state_q <= ST_RESP;
            end
          end
        end
        ST_ACTIVE: begin
          if (ack_sel) begin
            rdata_q <= ack_data;
            cyc_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q <= ERR_DATA;
            cyc_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            if (!err_q || err_clr_i) err_addr_q <= adr_q;
            state_q <= ST_RESP;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_RESP: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: doc/iomem_wb_bridge.md
# iomem_wb_bridge

- Parametrised bridge from the PicoSoC `iomem` bus to a multi-slave Wishbone B4 classic fabric.
- Replaces the single-target `iomem` to Wishbone state machine and its OR-combined slave return path.
- Adds per-slave address decode with one-hot `cyc`/`stb`, a muxed read path, and bus-error handling for unmapped addresses and unresponsive slaves.
- Sits between the `picosoc` `iomem` port and peripherals such as LED/button and VGA cores.

## Interface
Parameters:
- NUM_SLAVES, 4, number of Wishbone slaves (1..8)
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed 32-bit base address per slave; slave k is at [32k+31:32k]
- SLAVE_MASK, {NUM_SLAVES{32'hFFFF_0000}}, packed 32-bit mask per slave; hit when (addr & mask) == base
- WB_REGION, 8'h03, bridge claims a request when iomem_addr[31:24] >= WB_REGION
- TIMEOUT, 255, cycles to wait for ack before abort; 0 disables the timeout
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low. Clock is clk.
- iomem_valid  in  1  CPU request valid; held until ready
- iomem_ready  out  1  one-cycle completion pulse
- iomem_wstrb  in  4  byte write strobes; 0 means read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready is high
- wb_adr_o  out  32  shared address
- wb_dat_o  out  32  shared write data
- wb_we_o  out  1  shared write enable
- wb_sel_o  out  4  shared byte selects
- wb_cyc_o  out  NUM_SLAVES  one-hot cycle
- wb_stb_o  out  NUM_SLAVES  one-hot strobe
- wb_dat_i  in  32*NUM_SLAVES  packed slave read data
- wb_ack_i  in  NUM_SLAVES  slave acks
- err_o  out  1  sticky error flag
- err_addr_o  out  32  address of the first error since the last clear
- err_clr_i  in  1  clears err_o

## Operation
**States:** IDLE, ACTIVE, RESP.

**IDLE**
- Act only when iomem_valid is high and iomem_addr[31:24] >= WB_REGION. Other requests are ignored and iomem_ready stays 0, because other memory handles them.
- Decode:
  - Lowest-index slave hit wins on overlapping windows.
  - On a hit to slave k:
    - Latch wb_adr_o = addr and wb_dat_o = wdata.
    - Set wb_we_o = |wstrb.
    - Set wb_sel_o = wstrb for writes, 4'hF for reads.
    - Drive cyc[k] and stb[k] high, clear the timer, go to ACTIVE.
  - With no hit: set iomem_rdata = ERR_DATA, pulse iomem_ready, flag the error, go to RESP. No Wishbone cycle is issued.

**ACTIVE**
- ack[k] high: latch wb_dat_i[k] (data for writes is don't-care), drop cyc/stb/we, set iomem_ready = 1, go to RESP.
- Acks from non-selected slaves are ignored.
- Timer == TIMEOUT-1 with no ack: drop cyc/stb/we, set rdata = ERR_DATA, set iomem_ready = 1, flag the error, go to RESP.
- Ack arriving on the timeout cycle: the ack wins and no error is flagged.

**RESP**
- iomem_ready <= 0, go to IDLE.
- The CPU has dropped valid by the following cycle, so the same request is not re-issued.

**Error flagging**
- If err_o is 0: set err_o and latch err_addr_o.
- If err_o is already set: err_addr_o is kept.
- err_clr_i and a new error in the same cycle: the new error wins, err_o stays 1 and err_addr_o takes the new address.

**Timer:** width $clog2(TIMEOUT+1); saturates; counts only in ACTIVE.

## Timing
**Reset values:** iomem_ready=0, iomem_rdata=0, wb_adr_o=0, wb_dat_o=0, wb_we_o=0, wb_sel_o=0, wb_cyc_o=0, wb_stb_o=0, err_o=0, err_addr_o=0, state=IDLE.

**Reset mid-transfer:** all cyc/stb low on the next edge; no ready is issued.

**Latency**
- valid sampled in cycle 0.
- cyc/stb high in cycle 1.
- A slave that acks combinationally in cycle 1 gives iomem_ready in cycle 2; back in IDLE in cycle 3.
- Unmapped access: iomem_ready in cycle 1.
- Timeout: iomem_ready in cycle TIMEOUT+1.

**Bus rules**
- cyc and stb are never high for more than one slave.
- iomem_ready is never high for two consecutive cycles.

## Structure
- **Package `iomem_wb_pkg`:**
  - State enum.
  - Default ERR_DATA and WB_REGION constants.
  - Function `slave_field(vec, k)` for packed-array slicing.
- **Sub-module `wb_addr_decoder`:** combinational, priority one-hot hit vector plus `any_hit`, parametrised by NUM_SLAVES, SLAVE_BASE and SLAVE_MASK.

## Test plan
1. **Read hit.** Read 0x0300_0004 with slave0 at base 0x0300_0000 acking data 0x1234_5678 in cycle 1. Expect: cyc[0] only, sel=4'hF, we=0; ready in cycle 2 with rdata 0x1234_5678; err_o=0.
2. **Write hit.** Write wstrb=4'b0011 to slave2's window, slave2 acks after 3 cycles. Expect: sel=4'b0011, we=1, cyc[2] only; ready exactly one cycle after the ack.
3. **Unmapped.** Read 0x0F00_0000. Expect: no cyc; ready in cycle 1, rdata 0xDEAD_BEEF, err_o=1, err_addr_o=0x0F00_0000. A second unmapped access keeps the first address.
4. **Timeout.** TIMEOUT=8, slave never acks. Expect: cyc drops and ready arrives in cycle 9 with ERR_DATA and err_o set. err_clr_i with no new error clears the flag. err_clr_i in the same cycle as a new error leaves err_o=1.
5. **Wrong ack and out-of-region.** A non-selected slave acks while slave1 is active: ignored, completion waits for ack[1]. A request at 0x0200_0000 produces no Wishbone activity and no ready.
6. **Reset mid-transfer.** Drop resetn during ACTIVE. Expect: all outputs at their reset values next edge, no ready pulse; a new transfer completes normally afterwards.
